// File: rtl/modexp_sched.sv
// modexp_sched: round-robin scheduler sharing one modexp engine between NREQ requesters
module modexp_sched #(
  parameter int LEN = 256,
  parameter int NREQ = 2,
  parameter int TIMEOUT = 4096,
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int CW = $clog2(TIMEOUT) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*LEN-1:0]   req_a,
  input  logic [NREQ*LEN-1:0]   req_e,
  input  logic                  cfg_we,
  input  logic [1:0]            cfg_sel,
  input  logic [LEN-1:0]        cfg_data,
  output logic                  cfg_err,
  output logic                  me_start,
  output logic [LEN-1:0]        me_a,
  output logic [LEN-1:0]        me_e,
  output logic [LEN-1:0]        me_n,
  output logic [LEN-1:0]        me_n_prime,
  output logic [LEN-1:0]        me_r2,
  input  logic [LEN-1:0]        me_res,
  input  logic                  me_done,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IW-1:0]         rsp_id,
  output logic [LEN-1:0]        rsp_data,
  output logic                  rsp_timeout,
  output logic                  busy
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;
  state_t state;
  logic [LEN-1:0] cfg_n, cfg_np, cfg_r2, n_nx, np_nx, r2_nx;
  logic [2:0] cfg_set;
  logic [IW-1:0] ptr, gid, j;
  logic [CW-1:0] cnt;
  logic cfg_ok, cfg_wr, hit;
  assign cfg_ok = &cfg_set;
  assign cfg_wr = cfg_we && state == S_IDLE && cfg_sel != 2'd3;
  // a write landing on the accept edge must reach the engine operands too
  assign n_nx  = (cfg_wr && cfg_sel == 2'd0) ? cfg_data : cfg_n;
  assign np_nx = (cfg_wr && cfg_sel == 2'd1) ? cfg_data : cfg_np;
  assign r2_nx = (cfg_wr && cfg_sel == 2'd2) ? cfg_data : cfg_r2;
  assign busy = state != S_IDLE;
  always_comb begin
    req_ready = '0;
    gid = '0;
    j = '0;
    hit = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      j = IW'((int'(ptr) + k) % NREQ);
      if (!hit && req_valid[j]) begin
        hit = 1'b1;
        gid = j;
      end
    end
    if (hit && cfg_ok && state == S_IDLE) req_ready[gid] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cfg_n <= '0;
      cfg_np <= '0;
      cfg_r2 <= '0;
      cfg_set <= '0;
      ptr <= IW'(NREQ - 1);
      cnt <= '0;
      cfg_err <= 1'b0;
      me_start <= 1'b0;
      me_a <= '0;
      me_e <= '0;
      me_n <= '0;
      me_n_prime <= '0;
      me_r2 <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_data <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      me_start <= 1'b0;
      cfg_err <= cfg_we && !cfg_wr;
      cfg_n <= n_nx;
      cfg_np <= np_nx;
      cfg_r2 <= r2_nx;
      cfg_set <= cfg_set | (cfg_wr ? 3'(1 << cfg_sel) : 3'd0);
      case (state)
        S_IDLE: if (|req_ready) begin
          me_a <= req_a[gid*LEN +: LEN];
          me_e <= req_e[gid*LEN +: LEN];
          me_n <= n_nx;
          me_n_prime <= np_nx;
          me_r2 <= r2_nx;
          ptr <= gid;
          rsp_id <= gid;
          me_start <= 1'b1;
          state <= S_ISSUE;
        end
        S_ISSUE: begin
          cnt <= '0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // cnt==0 marks the first WAIT cycle, where a leftover done level is ignored
          if (cnt != '0 && me_done) begin
            rsp_data <= me_res;
            rsp_timeout <= 1'b0;
            rsp_valid <= 1'b1;
            state <= S_RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            rsp_data <= '0;
            rsp_timeout <= 1'b1;
            rsp_valid <= 1'b1;
            state <= S_RESP;
          end else begin
            cnt <= (&cnt) ? cnt : cnt + 1'b1;
          end
        end
        S_RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_modexp_sched.sv
// tb_modexp_sched: directed table-driven bench for modexp_sched with a stub engine
module tb_modexp_sched;
  localparam int LEN = 256, NREQ = 2, TO = 16;
  localparam logic [LEN-1:0] N  = 256'hfffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f;
  localparam logic [LEN-1:0] NP = 256'hc9bd1905155383999c46c2c295f2b761bcb223fedc24a059d838091dd2253531;
  localparam logic [LEN-1:0] R2 = 256'h1000007a2000e90a1;
  localparam logic [LEN-1:0] BA = 256'ha1b2c3d4e5f67890123456789012345678901234567890123456789012345678;
  localparam logic [LEN-1:0] BE = 256'h10001;
  localparam logic [LEN-1:0] BR = 256'h6529839e9bf0ce322932bdcc612f5f3866cf4c7abf15bff66b324e253bb35bc3;
  logic clk = 0, rst = 1;
  logic [NREQ-1:0] req_valid = '0, req_ready;
  logic [NREQ*LEN-1:0] req_a = '0, req_e = '0;
  logic cfg_we = 0, cfg_err;
  logic [1:0] cfg_sel = '0;
  logic [LEN-1:0] cfg_data = '0;
  logic me_start, me_done = 0;
  logic [LEN-1:0] me_a, me_e, me_n, me_n_prime, me_r2, me_res = '0;
  logic rsp_valid, rsp_ready = 0, rsp_timeout, busy;
  logic [0:0] rsp_id;
  logic [LEN-1:0] rsp_data;
  int tests = 0, fails = 0;
  int eng_lat = 3, eng_cnt = 0;
  logic [LEN-1:0] eng_val;
  typedef struct {
    logic [1:0] vm;
    logic [LEN-1:0] a0, a1, e;
    int lat;
    logic xid;
    logic [LEN-1:0] xd;
    logic xt;
    int xl;
  } vec_t;
  vec_t tbl[8];

  modexp_sched #(.LEN(LEN), .NREQ(NREQ), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_e(req_e), .cfg_we(cfg_we), .cfg_sel(cfg_sel),
    .cfg_data(cfg_data), .cfg_err(cfg_err), .me_start(me_start), .me_a(me_a),
    .me_e(me_e), .me_n(me_n), .me_n_prime(me_n_prime), .me_r2(me_r2),
    .me_res(me_res), .me_done(me_done), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  // stub engine: done pulses eng_lat cycles after the start cycle; eng_lat=0 never finishes
  always begin
    @(posedge clk); #1;
    me_done = 1'b0;
    if (eng_cnt > 0) begin
      eng_cnt--;
      if (eng_cnt == 0) begin
        me_done = 1'b1;
        me_res = eng_val;
      end
    end
    if (me_start) begin
      eng_cnt = eng_lat;
      eng_val = (me_a == BA && me_e == BE && me_n == N) ? BR : me_a + me_e;
    end
  end

  task automatic chk(input string nm, input logic [LEN-1:0] act, input logic [LEN-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic cfg_write(input logic [1:0] sel, input logic [LEN-1:0] d);
    cfg_we = 1; cfg_sel = sel; cfg_data = d;
    tick;
    cfg_we = 0;
  endtask

  task automatic do_job(input string nm, input logic [1:0] vm, input int lat, input int hold,
                        input bit cfgw, input logic xid, input logic [LEN-1:0] xd,
                        input logic xt, input int xl);
    int t, bad;
    logic [LEN-1:0] d0;
    eng_lat = lat;
    req_valid = vm;
    #1;
    t = 0;
    while (req_ready == '0 && t < 40) begin tick; t++; end
    chk({nm, "_grant"}, LEN'(req_ready), LEN'(2'b01 << xid));
    tick;
    req_valid = '0;
    chk({nm, "_start"}, LEN'(me_start), 1);
    tick;
    chk({nm, "_start_once"}, LEN'(me_start), 0);
    t = 1;
    while (!rsp_valid && t < 60) begin tick; t++; end
    chk({nm, "_rsp_lat"}, LEN'(t), LEN'(xl));
    chk({nm, "_id"}, LEN'(rsp_id), LEN'(xid));
    chk({nm, "_data"}, rsp_data, xd);
    chk({nm, "_tmo"}, LEN'(rsp_timeout), LEN'(xt));
    bad = 0;
    d0 = rsp_data;
    for (int i = 0; i < hold; i++) begin
      req_valid = vm;
      if (cfgw && i == 0) begin cfg_we = 1; cfg_sel = 2'd0; cfg_data = '0; end
      tick;
      cfg_we = 0;
      if (cfgw && i < 2) chk({nm, "_cfg_err"}, LEN'(cfg_err), LEN'(i == 0));
      if (!rsp_valid || rsp_data !== d0 || rsp_id !== xid || req_ready !== '0) bad++;
    end
    if (hold > 0) chk({nm, "_hold_stable"}, LEN'(bad), 0);
    req_valid = '0;
    rsp_ready = 1;
    tick;
    rsp_ready = 0;
    chk({nm, "_rsp_drop"}, LEN'({rsp_valid, busy}), 0);
  endtask

  initial begin
    int t;
    tbl[0] = '{2'b11, 100, 200, 7, 3, 1'b0, 107, 1'b0, 4};
    tbl[1] = '{2'b11, 300, 400, 5, 3, 1'b1, 405, 1'b0, 4};
    tbl[2] = '{2'b11, 11, 22, 1, 3, 1'b0, 12, 1'b0, 4};
    tbl[3] = '{2'b11, 1000, 2000, 24, 3, 1'b1, 2024, 1'b0, 4};
    tbl[4] = '{2'b01, 9, 9, 9, 0, 1'b0, 0, 1'b1, 17};
    tbl[5] = '{2'b11, 9, 9, 9, 1, 1'b1, 0, 1'b1, 17};
    tbl[6] = '{2'b10, 3, 50, 50, 16, 1'b1, 100, 1'b0, 17};
    tbl[7] = '{2'b11, 7, 70, 8, 2, 1'b0, 15, 1'b0, 3};
    tick; tick;
    rst = 0;
    chk("reset_outputs", LEN'({busy, rsp_valid, me_start, cfg_err, rsp_timeout}), 0);
    chk("reset_me_n", me_n, 0);
    // config gating: two of three registers written
    cfg_write(2'd0, N);
    chk("cfg_ok_write", LEN'(cfg_err), 0);
    cfg_write(2'd1, NP);
    req_a = {256'd0, 256'd5};
    req_e = {256'd6, 256'd6};
    req_valid = 2'b01;
    t = 0;
    for (int i = 0; i < 20; i++) begin
      tick;
      if (req_ready !== '0) t++;
    end
    chk("gate_no_ready", LEN'(t), 0);
    cfg_write(2'd2, R2);
    #1;
    chk("gate_ready_after_r2", LEN'(req_ready), 1);
    do_job("gate", 2'b01, 3, 0, 0, 1'b0, 11, 1'b0, 4);
    // reference vector from requester 1 with backpressure and a rejected config write
    req_a = {BA, 256'd0};
    req_e = {BE, BE};
    do_job("basic", 2'b10, 3, 10, 1, 1'b1, BR, 1'b0, 4);
    chk("basic_me_n", me_n, N);
    chk("basic_me_np", me_n_prime, NP);
    chk("basic_me_r2", me_r2, R2);
    chk("basic_me_a", me_a, BA);
    for (int i = 0; i < 8; i++) begin
      req_a = {tbl[i].a1, tbl[i].a0};
      req_e = {tbl[i].e, tbl[i].e};
      do_job($sformatf("vec%0d", i), tbl[i].vm, tbl[i].lat, 0, 0, tbl[i].xid, tbl[i].xd, tbl[i].xt, tbl[i].xl);
    end
    chk("cfg_unchanged_n", me_n, N);
    cfg_write(2'd3, 256'd1);
    chk("sel3_err", LEN'(cfg_err), 1);
    tick;
    chk("sel3_err_clear", LEN'(cfg_err), 0);
    // reset in the second WAIT cycle; the engine's later done must be ignored
    eng_lat = 5;
    req_a = {256'd1, 256'd1};
    req_valid = 2'b01;
    #1;
    t = 0;
    while (req_ready == '0 && t < 40) begin tick; t++; end
    tick;
    req_valid = '0;
    tick; tick;
    chk("pre_rst_busy", LEN'(busy), 1);
    rst = 1;
    tick;
    rst = 0;
    req_valid = 2'b01;
    #1;
    chk("rst_state", LEN'({busy, rsp_valid, me_start}), 0);
    chk("rst_ready_cfg_cleared", LEN'(req_ready), 0);
    chk("rst_me_a", me_a, 0);
    t = 0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (rsp_valid || busy) t++;
    end
    chk("rst_stale_done_ignored", LEN'(t), 0);
    req_valid = '0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/modexp_sched.md
Name: modexp_sched

Overview:
- Round-robin scheduler that shares one `modexp` engine (Montgomery modular exponentiation, LEN-bit) between NREQ requesters.
- Holds the modulus-side configuration (n, n_prime, r2_mod_n) in registers written through a config port.
- Accepts one (a, e) job at a time and pulses the engine start.
- Waits for done, or times out, and returns the result tagged with the requester index over a valid/ready response channel.

Parameters:
- LEN, 256, operand/result width; must match the engine's LEN.
- NREQ, 2, number of requesters (2..8).
- TIMEOUT, 4096, maximum cycles spent in WAIT before the job is aborted.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester accept; at most one bit high.
- req_a  in  NREQ*LEN  base, requester i at bits [i*LEN +: LEN].
- req_e  in  NREQ*LEN  exponent, same packing.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  2  0=n, 1=n_prime, 2=r2_mod_n, 3=reserved.
- cfg_data  in  LEN  config write data.
- cfg_err  out  1  one-cycle pulse: write rejected.
- me_start  out  1  engine start pulse.
- me_a, me_e, me_n, me_n_prime, me_r2  out  LEN each  engine operands.
- me_res  in  LEN  engine result.
- me_done  in  1  engine done.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  result accepted.
- rsp_id  out  max(1,clog2(NREQ))  requester index.
- rsp_data  out  LEN  result.
- rsp_timeout  out  1  job aborted by timeout; rsp_data=0.
- busy  out  1  state != IDLE.

Behaviour:
- Reset (sync, rst high at clk edge):
  - state=IDLE; all outputs 0.
  - Config registers and their written flags cleared.
  - RR pointer = NREQ-1, so requester 0 wins first.
  - rst has priority over everything, including mid-WAIT. The engine is not reset; a stale me_done is ignored because state is IDLE.
- cfg_ok = all three config registers written at least once since reset.
- Config writes:
  - Accepted only in IDLE with cfg_sel<3; take effect at that edge.
  - cfg_sel=3, or any write while not IDLE: write ignored, cfg_err=1 on the next cycle only.
  - A write in the same cycle as a request accept is committed; ISSUE drives the new value.
- Grant (combinational):
  - In IDLE with cfg_ok, the grant goes to the first i with req_valid[i], scanning from (ptr+1) mod NREQ upward and wrapping.
  - req_ready = onehot grant.
  - req_ready=0 in all other states or when !cfg_ok.
- States:
  - IDLE: on valid&ready for requester g, latch a/e of g into me_a/me_e and n/n_prime/r2 into me_n/me_n_prime/me_r2. Set ptr=g, id=g → ISSUE.
  - ISSUE: me_start=1 for exactly this cycle; clear timeout counter → WAIT.
  - WAIT: me_done is ignored in the first WAIT cycle (guards against a stale done level); from the second cycle on, the first me_done=1 sample ends the job.
    - Done: latch me_res into rsp_data, rsp_timeout=0 → RESP.
    - Timeout: if the counter reaches TIMEOUT-1 without done, rsp_data=0, rsp_timeout=1 → RESP.
    - Done and timeout in the same cycle: done wins.
  - RESP: rsp_valid=1 with rsp_id/rsp_data/rsp_timeout stable until rsp_ready. On rsp_valid&rsp_ready → IDLE; rsp_valid drops the next cycle.
- me_a..me_r2 hold stable from ISSUE through RESP.
- Latency:
  - Accept at edge k → me_start high in cycle k+1.
  - me_done sampled at edge d → rsp_valid high in cycle d+1.
  - Back-to-back: the earliest next accept is the cycle after the response handshake.
- Fairness: with all requesters continuously valid, grants rotate 0,1,…,NREQ-1,0.
- Timeout counter is width clog2(TIMEOUT)+1, saturating.

Test Plan:
- Basic job with real modexp, LEN=256:
  - Config n=fffffffffffffffffffffffffffffffffffffffffffffffffffffffefffffc2f, n_prime=c9bd1905155383999c46c2c295f2b761bcb223fedc24a059d838091dd2253531, r2=1000007a2000e90a1.
  - Requester 1: a=a1b2c3d4e5f67890123456789012345678901234567890123456789012345678, e=10001.
  - Expect me_start pulses once, 1 cycle after accept.
  - Expect rsp_id=1, rsp_data=6529839e9bf0ce322932bdcc612f5f3866cf4c7abf15bff66b324e253bb35bc3, rsp_timeout=0.
- Config gating:
  - Write only n and n_prime, then assert req_valid[0] → req_ready stays 0 for 20 cycles.
  - Write r2 → accepted on the next cycle.
- Round robin: both requesters valid for 4 jobs, rsp_ready tied 1 → rsp_id sequence 0,1,0,1.
- Backpressure and config errors:
  - Hold rsp_ready=0 for 10 cycles in RESP → rsp_valid, rsp_data, rsp_id stable; req_ready=0.
  - cfg_we during RESP → cfg_err pulses for 1 cycle and the config registers are unchanged.
  - cfg_sel=3 in IDLE → cfg_err pulses.
- Timeout: stub engine that never raises done, TIMEOUT=16 → rsp_valid 17 cycles after me_start, rsp_timeout=1, rsp_data=0; the next job still issues normally.
- Reset mid-WAIT:
  - Assert rst for 1 cycle during WAIT → next cycle busy=0, rsp_valid=0, req_ready=0 (config cleared).
  - A later me_done pulse produces no response.
